pgm_mem_port: RTL

PGM_MEM_PORT -- requirements
Module: pgm_mem_port

---
 rtl/pgm_mem_port_pkg.sv | 26 ++
 rtl/pgm_addr_reg.sv | 44 ++++
 rtl/pgm_mem_port.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/pgm_mem_port_pkg.sv
// Shared types and constants for the ZX programming memory port.
package pgm_mem_port_pkg;

  typedef enum logic [1:0] {
    SEL_CTRL = 2'd0,
    SEL_TEST = 2'd1,
    SEL_ADDR = 2'd2,
    SEL_DATA = 2'd3
  } io_sel_e;

  typedef enum logic [1:0] {
    ST_READY = 2'd0,
    ST_DRAIN = 2'd1,
    ST_COUNT = 2'd2
  } init_state_e;

  localparam int CTRL_INIT_BIT    = 7;
  localparam int CTRL_LED_BIT     = 6;
  localparam int CTRL_AUTOINC_BIT = 5;
  localparam int CTRL_DIR_BIT     = 4;
  localparam int CTRL_OVR_CLR_BIT = 1;

  localparam int INIT_CNT_W = 8;
  localparam int PHASE_W    = 2;

endpackage

// File: rtl/pgm_addr_reg.sv
// Address register loaded byte-by-byte through a phase counter, with +/-1 stepping.
module pgm_addr_reg
  import pgm_mem_port_pkg::*;
#(
  parameter int ADDR_W = 19
) (
  input  logic              clk,
  input  logic              clear,
  input  logic              load,
  input  logic [7:0]        din,
  input  logic              step,
  input  logic              dir,
  input  logic              phase_clr,
  output logic [ADDR_W-1:0] addr
);

  localparam int NPHASE = (ADDR_W + 7) / 8;

  logic [PHASE_W-1:0] phase;
  logic [ADDR_W-1:0]  loaded;

  // Only bits of the selected byte lane that exist in addr are replaced.
  always_comb begin
    loaded = addr;
    for (int i = 0; i < ADDR_W; i++) begin
      if ((i / 8) == int'(phase)) loaded[i] = din[i[2:0]];
    end
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      addr  <= '0;
      phase <= '0;
    end else begin
      if (load) begin
        addr  <= loaded;
        phase <= (phase == PHASE_W'(NPHASE - 1)) ? '0 : phase + PHASE_W'(1);
      end
      if (phase_clr) phase <= '0;
      if (step) addr <= dir ? addr - ADDR_W'(1) : addr + ADDR_W'(1);
    end
  end

endmodule

// File: rtl/pgm_mem_port.sv
// ZX-side I/O port bridging CTRL/TEST/ADDR/DATA registers onto a req/ack memory bus.
// Optional test register enabled by defining PGM_MEM_PORT_TESTREG_EN.
module pgm_mem_port
  import pgm_mem_port_pkg::*;
#(
  parameter int ADDR_W      = 19,
  parameter int INIT_CYCLES = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              io_wr_stb,
  input  logic              io_rd_stb,
  input  logic [1:0]        io_sel,
  input  logic [7:0]        io_din,
  output logic [7:0]        io_dout,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata,
  input  logic              mem_ack,
  output logic              led
);

  io_sel_e                 sel;
  init_state_e             state, state_nxt;
  logic [INIT_CNT_W-1:0]   cnt, cnt_nxt;
  logic                    wr, rd, busy, init_req, ack_valid;
  logic                    data_acc, data_ok, data_drop;
  logic                    autoinc, dir, overrun;
  logic [7:0]              rd_buf, ctrl_byte, test_byte;
  logic [ADDR_W-1:0]       addr;

  assign sel       = io_sel_e'(io_sel);
  assign wr        = io_wr_stb;
  assign rd        = io_rd_stb & ~io_wr_stb;
  assign ack_valid = mem_ack & mem_req;
  assign busy      = (state != ST_READY);
  assign init_req  = wr && (sel == SEL_CTRL) && io_din[CTRL_INIT_BIT];
  assign data_acc  = (wr || rd) && (sel == SEL_DATA);
  assign data_ok   = data_acc && !mem_req && !busy;
  assign data_drop = data_acc && !data_ok;
  assign ctrl_byte = {busy, led, autoinc, dir, 2'b00, overrun, mem_req};

  pgm_addr_reg #(.ADDR_W(ADDR_W)) u_addr (
    .clk       (clk),
    .clear     (rst || init_req),
    .load      (wr && (sel == SEL_ADDR)),
    .din       (io_din),
    .step      (data_ok && autoinc),
    .dir       (dir),
    .phase_clr (data_acc),
    .addr      (addr)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_COUNT;
      cnt   <= INIT_CNT_W'(INIT_CYCLES);
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // An init that arrives mid-transaction waits in DRAIN until the bus is quiet.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      ST_DRAIN: begin
        if (ack_valid) begin
          state_nxt = ST_COUNT;
          cnt_nxt   = INIT_CNT_W'(INIT_CYCLES);
        end
      end
      ST_COUNT: begin
        cnt_nxt = cnt - INIT_CNT_W'(1);
        if (cnt == INIT_CNT_W'(1)) state_nxt = ST_READY;
      end
      default: ;
    endcase
    if (init_req) begin
      if (mem_req && !ack_valid) begin
        state_nxt = ST_DRAIN;
        cnt_nxt   = '0;
      end else begin
        state_nxt = ST_COUNT;
        cnt_nxt   = INIT_CNT_W'(INIT_CYCLES);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      io_dout   <= 8'hFF;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= 8'h00;
      led       <= 1'b0;
      autoinc   <= 1'b0;
      dir       <= 1'b0;
      overrun   <= 1'b0;
      rd_buf    <= 8'h00;
    end else begin
      if (ack_valid) begin
        mem_req <= 1'b0;
        if (!mem_we && state != ST_DRAIN) rd_buf <= mem_rdata;
      end
      if (data_ok) begin
        mem_req  <= 1'b1;
        mem_we   <= wr;
        mem_addr <= addr;
        if (wr) mem_wdata <= io_din;
      end
      if (rd) begin
        case (sel)
          SEL_CTRL: io_dout <= ctrl_byte;
          SEL_TEST: io_dout <= test_byte;
          SEL_DATA: io_dout <= rd_buf;
          default:  io_dout <= 8'hFF;
        endcase
      end
      if (wr && sel == SEL_CTRL) begin
        if (io_din[CTRL_INIT_BIT]) begin
          led     <= 1'b0;
          autoinc <= 1'b0;
          dir     <= 1'b0;
          overrun <= 1'b0;
          rd_buf  <= 8'h00;
        end else begin
          led     <= led ^ io_din[CTRL_LED_BIT];
          autoinc <= io_din[CTRL_AUTOINC_BIT];
          dir     <= io_din[CTRL_DIR_BIT];
          if (io_din[CTRL_OVR_CLR_BIT]) overrun <= 1'b0;
        end
      end
      if (data_drop) overrun <= 1'b1;
    end
  end

`ifdef PGM_MEM_PORT_TESTREG_EN
  logic [8:0] treg;

  always_ff @(posedge clk) begin
    if (rst || init_req) treg <= 9'h000;
    else if (wr && sel == SEL_TEST) treg <= {~io_din, treg[8]};
  end

  assign test_byte = treg[7:0];
`else
  assign test_byte = 8'hFF;
`endif

endmodule
